// File: rtl/axis_elastic_buffer.sv
// AXI-stream elastic buffer: DEPTH-entry circular store with TKEEP/TLAST sideband and a registered ready.
// Define AXIS_ELASTIC_BUFFER_BYPASS_EN for zero-latency fall-through when the buffer is empty.
module axis_elastic_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int KW   = DW / 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic [KW-1:0] i_keep,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [KW-1:0] o_keep,
    output logic          o_last,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + KW + 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          full_s;
    logic          empty_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    // Occupancy flags, handshakes and downstream beat selection
    always_comb begin
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s  = (wr_ptr_q == rd_ptr_q);
        bypass_s = 1'b0;
`ifdef AXIS_ELASTIC_BUFFER_BYPASS_EN
        // An empty buffer hands the beat straight through when downstream can take it.
        bypass_s = empty_s && i_valid && i_ready && i_reset;
`else
        bypass_s = 1'b0;
`endif
        o_ready = !full_s;
        o_valid = i_reset && (!empty_s || bypass_s);
        push_s  = i_reset && i_valid && !full_s && !bypass_s;
        pop_s   = o_valid && i_ready && !bypass_s;
        if (bypass_s) begin
            head_s = {i_last, i_keep, i_data};
        end else begin
            head_s = mem_q[rd_ptr_q[AW-1:0]];
        end
        o_last  = head_s[EW-1];
        o_keep  = head_s[DW +: KW];
        o_data  = head_s[DW-1:0];
        o_count = count_q;
    end

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i_last, i_keep, i_data};
        end
    end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Self-checking bench for axis_elastic_buffer: vector table, directed corner cases and a
// randomized run scored against a queue-based reference model.
module tb_axis_elastic_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int KW    = 4;
    localparam int CW    = 3;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [KW-1:0] i_keep;
    logic          i_last;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [KW-1:0] o_keep;
    logic          o_last;
    logic [CW-1:0] o_count;

    axis_elastic_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_keep  (i_keep),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          ev;
        logic [DW-1:0] ed;
        int            ecnt;
        logic          erdy;
    } vec_t;

    beat_t         q[$];
    vec_t          tbl[10];
    int            errors = 0;
    int            checks = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_count;
    logic [DW-1:0] s_data;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus: apply inputs, check outputs against the model, then advance the model.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic l, input logic r, output logic acc);
        logic  byp;
        logic  ev;
        beat_t head;
        @(negedge i_clk);
        i_valid = v; i_data = d; i_keep = k; i_last = l; i_ready = r;
        #1;
        byp = 1'b0;
`ifdef AXIS_ELASTIC_BUFFER_BYPASS_EN
        byp = (q.size() == 0) && v && r;
`endif
        ev = (q.size() > 0) || byp;
        chk("o_valid", o_valid, ev);
        chk("o_ready", o_ready, q.size() < DEPTH);
        chk("o_count", o_count, q.size());
        if (ev) begin
            if (byp) begin
                head.d = d; head.k = k; head.l = l;
            end else begin
                head = q[0];
            end
            chk("o_data", o_data, head.d);
            chk("o_keep", o_keep, head.k);
            chk("o_last", o_last, head.l);
            if (hold_prev) chk("stable_data", o_data, prev_data);
        end
        s_valid = o_valid; s_ready = o_ready; s_count = o_count; s_data = o_data;
        hold_prev = o_valid && !r;
        prev_data = o_data;
        acc = v && (q.size() < DEPTH);
        if (!byp) begin
            if ((q.size() > 0) && r) void'(q.pop_front());
            if (acc) begin
                head.d = d; head.k = k; head.l = l;
                q.push_back(head);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        #1;
        chk("valid_in_reset", o_valid, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_count", o_count, 3'd0);
        chk("rst_ready", o_ready, 1'b1);
        q.delete();
        hold_prev = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   idx;
        int   cyc;
        logic v;
        logic r;
        i_reset = 1'b0; i_valid = 1'b0; i_data = '0; i_keep = '0; i_last = 1'b0; i_ready = 1'b0;

        tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  0, 1'b1};
        tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 32'hA0, 1, 1'b1};
        tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 32'hA0, 2, 1'b1};
        tbl[3] = '{1'b1, 32'hA3, 1'b0, 1'b1, 32'hA0, 3, 1'b1};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hA0, 4, 1'b0};
        tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA0, 4, 1'b0};
        tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 3, 1'b1};
        tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA2, 2, 1'b1};
        tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA3, 1, 1'b1};
        tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  0, 1'b1};

        do_reset();

        // Fill to full, then drain in order
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, 4'b1111, 1'b0, tbl[i].r, acc);
            chk("tbl_valid", s_valid, tbl[i].ev);
            chk("tbl_ready", s_ready, tbl[i].erdy);
            chk("tbl_count", s_count, tbl[i].ecnt);
            if (tbl[i].ev) chk("tbl_data", s_data, tbl[i].ed);
        end

        // Streaming through pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i, 4'b1111, 1'b0, 1'b1, acc);
`ifdef AXIS_ELASTIC_BUFFER_BYPASS_EN
            chk("stream_count", s_count, 3'd0);
`else
            if (i > 0) chk("stream_count", s_count, 3'd1);
`endif
        end
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);

        // Randomized backpressure with packet sideband
        idx = 0; cyc = 0; v = 1'b0;
        while ((idx < 100) && (cyc < 2000)) begin
            if (!v) v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 1);
            drive(v, 32'hB000_0000 + idx, ((idx % 8) == 7) ? 4'b0011 : 4'b1111,
                  (idx % 8) == 7, r, acc);
            if (acc) begin
                idx++;
                v = 1'b0;
            end
            cyc++;
        end
        chk("random_done", idx, 100);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);
        chk("random_drained", s_count, 3'd0);

        // Simultaneous push and pop at count 2
        drive(1'b1, 32'hC0, 4'b1111, 1'b0, 1'b0, acc);
        drive(1'b1, 32'hC1, 4'b1111, 1'b0, 1'b0, acc);
        drive(1'b1, 32'hC2, 4'b1111, 1'b0, 1'b1, acc);
        chk("pushpop_count", s_count, 3'd2);
        chk("pushpop_head", s_data, 32'hC0);
        drive(1'b1, 32'hC3, 4'b1111, 1'b1, 1'b1, acc);
        chk("pushpop_count2", s_count, 3'd2);
        chk("pushpop_head2", s_data, 32'hC1);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);

        // Reset with three beats stored
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hD0 + i, 4'b1111, 1'b0, 1'b0, acc);
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b0, acc);
        chk("pre_reset_count", s_count, 3'd3);
        do_reset();
        drive(1'b1, 32'h55, 4'b1111, 1'b1, 1'b0, acc);
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);
        chk("first_after_reset", s_data, 32'h55);
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);
        chk("after_reset_empty", s_valid, 1'b0);

        // Empty buffer with a ready downstream
        drive(1'b1, 32'h77, 4'b1111, 1'b0, 1'b1, acc);
`ifdef AXIS_ELASTIC_BUFFER_BYPASS_EN
        chk("bypass_valid", s_valid, 1'b1);
        chk("bypass_data", s_data, 32'h77);
        chk("bypass_count", s_count, 3'd0);
`else
        chk("nobypass_valid", s_valid, 1'b0);
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);
        chk("nobypass_data", s_data, 32'h77);
`endif
        drive(1'b0, 32'h0, 4'b0, 1'b0, 1'b1, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_elastic_buffer.md
Name: axis_elastic_buffer

Overview:
- Parametrised successor to the single-entry skid stage: an AXI-stream elastic buffer with DEPTH entries and TKEEP/TLAST sideband.
- o_ready depends only on registered state, so it breaks the ready path.
- Inserted between pipeline stages of the header-insertion datapath and its neighbours wherever backpressure must be absorbed over more than one beat.

Parameters:
- DW, 32, data width in bits; multiple of 8.
- DEPTH, 4, number of storage entries; power of 2, at least 2.
- KW, DW/8, keep width; derived, not overridden.
- CW, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_reset  in  1  synchronous reset, active-low.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  upstream ready; registered.
- i_data  in  DW  upstream data.
- i_keep  in  KW  upstream byte enables.
- i_last  in  1  upstream end-of-packet.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  DW  downstream data.
- o_keep  out  KW  downstream byte enables.
- o_last  out  1  downstream end-of-packet.
- o_count  out  CW  entries currently stored (0..DEPTH).

Behaviour:
- Reset (i_reset==0 at posedge):
  - wr_ptr=rd_ptr=0, count=0.
  - o_valid=0, o_ready=1 from the next cycle, o_count=0.
  - Storage contents are not cleared.
  - Reset mid-packet discards all stored beats without emitting them.
  - o_valid is also forced 0 combinationally while i_reset==0.
- Pointers:
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - Storage is indexed by the low log2(DEPTH) bits.
  - full = MSBs differ and low bits are equal.
  - empty = pointers are equal.
- Handshakes:
  - push = i_valid && o_ready.
  - pop = o_valid && i_ready.
- Storage write: on push, {i_last, i_keep, i_data} is written at wr_ptr and wr_ptr increments.
- Storage read: on pop, rd_ptr increments.
- Outputs:
  - o_data/o_keep/o_last are the entry at rd_ptr.
  - o_valid = !empty.
- o_ready = !full, derived from registered count only; it never depends on i_ready in the same cycle.
- Count update:
  - push && !pop: count+1.
  - pop && !push: count-1.
  - both or neither: unchanged.
  - o_count = count.
- Latency: a beat pushed in cycle N is visible on o_valid in cycle N+1 at the earliest (base build).
- Full (count==DEPTH):
  - o_ready=0.
  - A pop in this cycle raises o_ready in the next cycle. This costs one bubble of upstream throughput only at full.
- Empty (count==0): o_valid=0; o_data/o_keep/o_last are don't-care.
- Simultaneous push and pop at any count 0<count<DEPTH: both take effect; count holds.
- AXI-stream stability:
  - While o_valid && !i_ready, o_data/o_keep/o_last/o_valid hold stable.
  - Beats are never dropped, duplicated or reordered.
- No decoding of i_keep/i_last: they travel as opaque payload.
- Sustained throughput with i_valid=i_ready=1: one beat per cycle.

Optional Feature:
- Macro: AXIS_ELASTIC_BUFFER_BYPASS_EN.
- Defined (zero-latency fall-through):
  - When count==0, i_valid==1 and i_ready==1, the input beat is driven combinationally to o_data/o_keep/o_last with o_valid=1.
  - That beat is not written; pointers and count are unchanged.
  - When count==0 and i_ready==0, the beat is written normally.
  - When count>0, behaviour is identical to the base build, preserving order.
  - o_ready remains registered (!full).
- Not defined:
  - No combinational input-to-output path.
  - Minimum latency is 1 cycle, as above.

Test Plan:
- Fill to full: i_ready=0, push 0xA0..0xA3 (DEPTH=4) → o_count reaches 4, o_ready=0 after the 4th beat. Then i_ready=1 → output order A0,A1,A2,A3; o_ready returns to 1 the cycle after the first pop.
- Streaming and wrap-around: i_valid=i_ready=1 for 20 beats 0..19 → each beat out exactly once, in order.
  - Base build: one cycle late; o_count stays at 1.
  - Bypass build: same cycle; o_count stays at 0.
  - Pointers wrap past 2*DEPTH without error.
- Random backpressure: i_ready toggles at 50%, 100 beats with i_keep=4'b1111 and i_last on every 8th beat (last beat i_keep=4'b0011) → scoreboard matches data/keep/last exactly; o_data stable while o_valid && !i_ready.
- Simultaneous push/pop at count=2 → o_count stays 2; no beat lost.
- Reset mid-operation: count=3, drive i_reset=0 for one cycle → next cycle o_valid=0, o_count=0, o_ready=1. A subsequent beat 0x55 is the first beat out.
- Bypass build, empty with i_ready=1, push 0x77 → o_valid=1 and o_data=0x77 in the same cycle; o_count stays 0.
